mem_port_arbiter: RTL and testbench

- Shares the single physical data-memory port (DPI pmem read/write path) between two requesters: m0 = instruction fetch, m1 = load/store unit.
- Round-robin arbitration, one outstanding transaction at a time.
- Translates the 3-bit mem_op into a byte length for writes.
- Performs sign/zero extension of read data before returning it to the winning requester.

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction fetch (m0) and load/store (m1).
// Optional timeout watchdog with mem_err output is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_we,
    input  logic [2:0]  m0_op,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_resp_valid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_we,
    input  logic [2:0]  m1_op,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_resp_valid,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_len,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic        mem_err
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    generate
        if ((1 << CNT_W) <= TIMEOUT) begin : g_bad_cfg
            $error("CNT_W too narrow to count to TIMEOUT");
        end
    endgenerate

    logic [1:0]  state;
    logic        last_grant;
    logic        grant;
    logic        we_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        any_req;
    logic        pick;
    logic        op_legal;

    function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] d);
        case (op)
            3'b000:  extend = {{24{d[7]}}, d[7:0]};
            3'b001:  extend = {{16{d[15]}}, d[15:0]};
            3'b100:  extend = {24'h0, d[7:0]};
            3'b101:  extend = {16'h0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    // On a tie the requester that did not win last time is chosen.
    assign any_req  = m0_req_valid | m1_req_valid;
    assign pick     = m1_req_valid & (~m0_req_valid | ~last_grant);
    assign op_legal = (op_q[1:0] != 2'b11) && (op_q != 3'b110);

    assign m0_req_ready = (state == IDLE) && !rst && any_req && !pick;
    assign m1_req_ready = (state == IDLE) && !rst && any_req && pick;

    assign mem_valid = (state == ISSUE) && op_legal;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        mem_len = 3'd0;
        if (mem_valid) begin
            case (op_q[1:0])
                2'b00:   mem_len = 3'd1;
                2'b01:   mem_len = 3'd2;
                2'b10:   mem_len = 3'd4;
                default: mem_len = 3'd0;
            endcase
        end
    end

    assign m0_resp_valid = (state == RESP) && !grant;
    assign m1_resp_valid = (state == RESP) && grant;
    assign m0_rdata      = m0_resp_valid ? rdata_q : 32'h0;
    assign m1_rdata      = m1_resp_valid ? rdata_q : 32'h0;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             err_q;

    assign mem_err = (state == RESP) && err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            we_q       <= 1'b0;
            op_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt        <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= pick;
                        last_grant <= pick;
                        we_q       <= pick ? m1_we    : m0_we;
                        op_q       <= pick ? m1_op    : m0_op;
                        addr_q     <= pick ? m1_addr  : m0_addr;
                        wdata_q    <= pick ? m1_wdata : m0_wdata;
                        rdata_q    <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Illegal ops never reach memory and answer with zero data.
                    if (!op_legal) begin
                        rdata_q <= 32'h0;
                        state   <= RESP;
                    end else if (mem_ready) begin
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt     <= '0;
`endif
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= we_q ? 32'h0 : extend(op_q, mem_rdata);
                        state   <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rdata_q <= 32'hDEADBEEF;
                        err_q   <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; also exercises the timeout path
// when built with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_we, m0_resp_valid;
    logic [2:0]  m0_op;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req_valid, m1_req_ready, m1_we, m1_resp_valid;
    logic [2:0]  m1_op;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_valid, mem_ready, mem_we, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_len;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        mem_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req_valid   (m0_req_valid),
        .m0_req_ready   (m0_req_ready),
        .m0_we          (m0_we),
        .m0_op          (m0_op),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_resp_valid  (m0_resp_valid),
        .m0_rdata       (m0_rdata),
        .m1_req_valid   (m1_req_valid),
        .m1_req_ready   (m1_req_ready),
        .m1_we          (m1_we),
        .m1_op          (m1_op),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_resp_valid  (m1_resp_valid),
        .m1_rdata       (m1_rdata),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_len        (mem_len),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .mem_err        (mem_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rdy(input int m);
        return (m == 1) ? m1_req_ready : m0_req_ready;
    endfunction

    function automatic logic rv(input int m);
        return (m == 1) ? m1_resp_valid : m0_resp_valid;
    endfunction

    function automatic logic [31:0] rd(input int m);
        return (m == 1) ? m1_rdata : m0_rdata;
    endfunction

    task automatic drive(input int m, input logic v, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 1) begin
            m1_req_valid = v; m1_we = we; m1_op = op; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req_valid = v; m0_we = we; m0_op = op; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // Called one step after the accepting edge; returns one step after the RESP->IDLE edge.
    task automatic serve(input int m, input logic legal, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] len, input logic [31:0] raw,
                         input logic [31:0] exp, input int stall);
        if (!legal) begin
            @(negedge clk);
            check("illegal_no_mem_valid", mem_valid, 1'b0);
            check("illegal_no_ready", {m0_req_ready, m1_req_ready}, 2'b00);
            @(posedge clk); #1;
        end else begin
            mem_ready = 1'b0;
            mem_resp_valid = 1'b1;
            mem_rdata = 32'hBAADF00D;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("stall_mem_valid", mem_valid, 1'b1);
                check("stall_mem_addr", mem_addr, addr);
                check("stall_mem_wdata", mem_wdata, wdata);
                check("stall_mem_we", mem_we, we);
                check("stall_mem_len", mem_len, len);
                check("stall_no_resp", rv(m), 1'b0);
                @(posedge clk); #1;
            end
            mem_ready = 1'b1;
            @(negedge clk);
            check("issue_mem_valid", mem_valid, 1'b1);
            check("issue_mem_addr", mem_addr, addr);
            check("issue_mem_wdata", mem_wdata, wdata);
            check("issue_mem_we", mem_we, we);
            check("issue_mem_len", mem_len, len);
            check("issue_no_ready", {m0_req_ready, m1_req_ready}, 2'b00);
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_resp_valid = 1'b1;
            mem_rdata = raw;
            @(negedge clk);
            check("wait_mem_valid_low", mem_valid, 1'b0);
            check("wait_no_resp", rv(m), 1'b0);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            mem_rdata = 32'h5A5A5A5A;
        end
        @(negedge clk);
        check("resp_valid", rv(m), 1'b1);
        check("resp_rdata", rd(m), exp);
        check("other_resp_valid", rv(1 - m), 1'b0);
        check("other_rdata", rd(1 - m), 32'h0);
`ifdef MEM_ARB_TIMEOUT_EN
        check("resp_no_err", mem_err, 1'b0);
`endif
        @(posedge clk); #1;
    endtask

    task automatic txn(input int m, input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] len, input logic [31:0] raw,
                       input logic [31:0] exp, input int stall, input logic legal);
        drive(m, 1'b1, we, op, addr, wdata);
        @(negedge clk);
        check("grant_ready", rdy(m), 1'b1);
        check("other_ready", rdy(1 - m), 1'b0);
        check("idle_no_resp", {m0_resp_valid, m1_resp_valid}, 2'b00);
        @(posedge clk); #1;
        drive(m, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        serve(m, legal, we, addr, wdata, len, raw, exp, stall);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {m0_req_ready, m1_req_ready}, 2'b00);
        check("rst_resp", {m0_resp_valid, m1_resp_valid}, 2'b00);
        check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_mem_len", mem_len, 3'd0);
        check("rst_mem_fields", {31'h0, mem_we} | mem_addr | mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Tie right after reset, both held: m0, m1, m0, m1.
        drive(0, 1'b1, 1'b0, 3'b010, 32'h00001000, 32'h0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h80000000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("tie_m0_ready", m0_req_ready, (k % 2) == 0);
            check("tie_m1_ready", m1_req_ready, (k % 2) == 1);
            @(posedge clk); #1;
            serve(k % 2, 1'b1, 1'b0, (k % 2) ? 32'h80000000 : 32'h00001000, 32'h0, 3'd4,
                  32'h11110000 + k, 32'h11110000 + k, 0);
        end
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Load extensions, store, backpressure, illegal op.
        txn(1, 1'b0, 3'b000, 32'h80000010, 32'h0, 3'd1, 32'h000000F0, 32'hFFFFFFF0, 0, 1'b1);
        txn(1, 1'b0, 3'b100, 32'h80000010, 32'h0, 3'd1, 32'h000000F0, 32'h000000F0, 0, 1'b1);
        txn(0, 1'b0, 3'b001, 32'h80000022, 32'h0, 3'd2, 32'h12348001, 32'hFFFF8001, 0, 1'b1);
        txn(0, 1'b0, 3'b101, 32'h80000022, 32'h0, 3'd2, 32'h12348001, 32'h00008001, 0, 1'b1);
        txn(1, 1'b0, 3'b010, 32'h80000040, 32'h0, 3'd4, 32'hCAFEBABE, 32'hCAFEBABE, 0, 1'b1);
        txn(1, 1'b1, 3'b001, 32'h80000050, 32'h12345678, 3'd2, 32'hFFFFFFFF, 32'h0, 0, 1'b1);
        txn(0, 1'b1, 3'b010, 32'h80000060, 32'hA5A5C3C3, 3'd4, 32'hFFFFFFFF, 32'h0, 5, 1'b1);
        txn(1, 1'b0, 3'b111, 32'h80000070, 32'h0, 3'd0, 32'h0, 32'h0, 0, 1'b0);
        txn(0, 1'b1, 3'b110, 32'h80000074, 32'hFFFFFFFF, 3'd0, 32'h0, 32'h0, 0, 1'b0);

        // Reset while m0 is in WAIT; the late response must be dropped.
        drive(0, 1'b1, 1'b0, 3'b010, 32'h80000080, 32'h0);
        @(negedge clk);
        check("rw_grant", m0_req_ready, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h12345678;
        @(negedge clk);
        check("rw_no_resp_a", {m0_resp_valid, m1_resp_valid}, 2'b00);
        check("rw_no_mem_valid", mem_valid, 1'b0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        check("rw_no_resp_b", {m0_resp_valid, m1_resp_valid}, 2'b00);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 3'b000, 32'h00002000, 32'h0);
        drive(1, 1'b1, 1'b0, 3'b000, 32'h80002000, 32'h0);
        @(negedge clk);
        check("rw_tie_m0", m0_req_ready, 1'b1);
        check("rw_tie_m1", m1_req_ready, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        serve(0, 1'b1, 1'b0, 32'h00002000, 32'h0, 3'd1, 32'h0000007F, 32'h0000007F, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // No downstream response: forced error answer after TIMEOUT WAIT cycles.
        drive(1, 1'b1, 1'b0, 3'b010, 32'h80000090, 32'h0);
        @(negedge clk);
        check("to_grant", m1_req_ready, 1'b1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!seen) check("to_err_before_resp", mem_err, m1_resp_valid);
            seen = m1_resp_valid;
        end
        check("to_resp_seen", seen, 1'b1);
        check("to_rdata", m1_rdata, 32'hDEADBEEF);
        check("to_mem_err", mem_err, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_err_cleared", mem_err, 1'b0);
`else
        seen = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
